// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: default widths and the
// launch FSM state encoding.
package uart_tx_buffer_pkg;

    localparam int NDATA_BITS_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer-side push port and transmitter-side launch port of the UART
// transmit buffer, bundled with master (environment) and slave (buffer) views.
interface uart_tx_buffer_if
    import uart_tx_buffer_pkg::*;
#(
    parameter int NDATA_BITS = NDATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) ();
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Push side: i_wr is a fire-and-forget strobe, not a valid/ready pair; a
    // push while full is dropped and reported on o_overflow. Launch side:
    // o_tx_start is a 1-cycle request accepted only while i_tx_ready is high,
    // and o_tx_data stays stable until i_tx_ready falls and rises again.
    logic                  i_wr;
    logic [NDATA_BITS-1:0] i_wr_data;
    logic                  o_full;
    logic                  o_empty;
    logic [CW-1:0]         o_count;
    logic                  o_overflow;
    logic                  i_tx_ready;
    logic                  o_tx_start;
    logic [NDATA_BITS-1:0] o_tx_data;

    modport slave (
        input  i_wr, i_wr_data, i_tx_ready,
        output o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );

    modport master (
        output i_wr, i_wr_data, i_tx_ready,
        input  o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and drop-on-full overflow pulse.
// The head entry is presented combinationally on o_rd_data.
module sync_fifo #(
    parameter int NDATA_BITS = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_wr,
    input  logic [NDATA_BITS-1:0]                i_wr_data,
    input  logic                                 i_rd,
    output logic [NDATA_BITS-1:0]                o_rd_data,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_count,
    output logic                                 o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [NDATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    assign o_full    = (count_q == CW'(FIFO_DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign pop  = i_rd && !o_empty;
    assign push = i_wr && (!o_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = i_wr && !push;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus launch FSM feeding uart_transmitter one frame at a time,
// pacing on the transmitter's ready handshake.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int NDATA_BITS = NDATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      i_clock,
    input  logic      i_reset,
    uart_tx_buffer_if.slave bus,
    output tx_state_t o_state
);
    tx_state_t             state_q, state_d;
    logic                  tx_start_q, tx_start_d;
    logic [NDATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                  fifo_rd;
    logic                  fifo_empty;
    logic [NDATA_BITS-1:0] fifo_head;

    sync_fifo #(
        .NDATA_BITS (NDATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_wr       (bus.i_wr),
        .i_wr_data  (bus.i_wr_data),
        .i_rd       (fifo_rd),
        .o_rd_data  (fifo_head),
        .o_full     (bus.o_full),
        .o_empty    (fifo_empty),
        .o_count    (bus.o_count),
        .o_overflow (bus.o_overflow)
    );

    assign bus.o_empty = fifo_empty;

    // The transmitter samples o_tx_data combinationally for the whole frame,
    // so the byte only changes on a pop out of IDLE.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_rd    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.i_tx_ready) begin
                    fifo_rd    = 1'b1;
                    tx_data_d  = fifo_head;
                    tx_start_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH:    state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!bus.i_tx_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.i_tx_ready)  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: cycle table plus full/overflow, push+pop,
// burst against a transmitter model, and mid-frame reset sequences.
module tb_uart_tx_buffer;
    import uart_tx_buffer_pkg::*;

    localparam int W     = 8;
    localparam int D     = 16;
    localparam int FRAME = 20;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      man_ready;
    logic      model_en;
    logic      model_ready;
    tx_state_t state;

    always #5 clk = ~clk;

    uart_tx_buffer_if #(.NDATA_BITS(W), .FIFO_DEPTH(D)) bus ();

    assign bus.i_tx_ready = model_en ? model_ready : man_ready;

    uart_tx_buffer #(.NDATA_BITS(W), .FIFO_DEPTH(D)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus),
        .o_state (state)
    );

    // Transmitter model: accepts a start while ready, then stays busy FRAME cycles.
    int         busy_cnt = 0;
    logic [W-1:0] held = '0;
    logic [W-1:0] got_q[$];
    int         n_starts = 0;
    int         n_hold_err = 0;
    int         n_start_err = 0;

    always @(posedge clk) begin
        if (!model_en || !rst_n) begin
            busy_cnt    <= 0;
            model_ready <= 1'b1;
        end else if (busy_cnt == 0) begin
            if (bus.o_tx_start) begin
                got_q.push_back(bus.o_tx_data);
                held        <= bus.o_tx_data;
                n_starts    <= n_starts + 1;
                busy_cnt    <= FRAME;
                model_ready <= 1'b0;
            end
        end else begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) model_ready <= 1'b1;
            if (bus.o_tx_data != held) n_hold_err <= n_hold_err + 1;
            if (bus.o_tx_start) n_start_err <= n_start_err + 1;
        end
    end

    // Scoreboard and counters
    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic      wr;
        logic [7:0] data;
        logic      rdy;
        logic      start;
        logic [7:0] tx_data;
        logic [4:0] cnt;
        logic      full;
        logic      empty;
        logic      ovf;
        tx_state_t st;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic wr, logic [7:0] data, logic rdy, logic start,
                                logic [7:0] tx_data, logic [4:0] cnt, logic full,
                                logic empty, logic ovf, tx_state_t st);
        vec_t v;
        v.wr = wr; v.data = data; v.rdy = rdy; v.start = start; v.tx_data = tx_data;
        v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf; v.st = st;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.i_wr      = 1'b1;
        bus.i_wr_data = d;
        step();
        bus.i_wr      = 1'b0;
    endtask

    // From IDLE with a byte queued: launch it, run one frame by hand, return to IDLE.
    task automatic drain_one(input logic [7:0] exp);
        man_ready = 1'b1;
        step();
        check("drain_start", 32'(bus.o_tx_start), 32'd1);
        check("drain_data", 32'(bus.o_tx_data), 32'(exp));
        step();
        man_ready = 1'b0;
        step();
        check("drain_hold", 32'(bus.o_tx_data), 32'(exp));
        man_ready = 1'b1;
        step();
    endtask

    initial begin
        logic [18:0] act_v, exp_v;
        int          cyc;
        int          base;
        int          base_s;

        // Reset with a push attempt pending
        model_en      = 1'b0;
        man_ready     = 1'b1;
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'hAA;
        rst_n         = 1'b0;
        repeat (3) step();
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_start", 32'(bus.o_tx_start), 32'd0);
        check("rst_data", 32'(bus.o_tx_data), 32'h00);
        check("rst_ovf", 32'(bus.o_overflow), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        bus.i_wr = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("post_rst_empty", 32'(bus.o_empty), 32'd1);
        check("post_rst_start", 32'(bus.o_tx_start), 32'd0);

        // Cycle table: {wr, data, ready} -> {start, tx_data, count, full, empty, ovf, state}
        vecs[0]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, ST_IDLE);
        vecs[1]  = mk(1, 8'h41, 1, 0, 8'h00, 1, 0, 0, 0, ST_IDLE);
        vecs[2]  = mk(0, 8'h00, 1, 1, 8'h41, 0, 0, 1, 0, ST_LAUNCH);
        vecs[3]  = mk(0, 8'h00, 1, 0, 8'h41, 0, 0, 1, 0, ST_WAIT_BUSY);
        vecs[4]  = mk(0, 8'h00, 0, 0, 8'h41, 0, 0, 1, 0, ST_WAIT_DONE);
        vecs[5]  = mk(1, 8'h42, 0, 0, 8'h41, 1, 0, 0, 0, ST_WAIT_DONE);
        vecs[6]  = mk(0, 8'h00, 0, 0, 8'h41, 1, 0, 0, 0, ST_WAIT_DONE);
        vecs[7]  = mk(0, 8'h00, 1, 0, 8'h41, 1, 0, 0, 0, ST_IDLE);
        vecs[8]  = mk(0, 8'h00, 1, 1, 8'h42, 0, 0, 1, 0, ST_LAUNCH);
        vecs[9]  = mk(0, 8'h00, 1, 0, 8'h42, 0, 0, 1, 0, ST_WAIT_BUSY);
        vecs[10] = mk(0, 8'h00, 1, 0, 8'h42, 0, 0, 1, 0, ST_WAIT_BUSY);
        vecs[11] = mk(0, 8'h00, 0, 0, 8'h42, 0, 0, 1, 0, ST_WAIT_DONE);
        vecs[12] = mk(0, 8'h00, 1, 0, 8'h42, 0, 0, 1, 0, ST_IDLE);
        vecs[13] = mk(1, 8'h43, 0, 0, 8'h42, 1, 0, 0, 0, ST_IDLE);
        vecs[14] = mk(0, 8'h00, 0, 0, 8'h42, 1, 0, 0, 0, ST_IDLE);
        vecs[15] = mk(0, 8'h00, 1, 1, 8'h43, 0, 0, 1, 0, ST_LAUNCH);
        vecs[16] = mk(0, 8'h00, 1, 0, 8'h43, 0, 0, 1, 0, ST_WAIT_BUSY);
        vecs[17] = mk(0, 8'h00, 0, 0, 8'h43, 0, 0, 1, 0, ST_WAIT_DONE);
        vecs[18] = mk(0, 8'h00, 1, 0, 8'h43, 0, 0, 1, 0, ST_IDLE);
        vecs[19] = mk(1, 8'h44, 1, 0, 8'h43, 1, 0, 0, 0, ST_IDLE);
        vecs[20] = mk(1, 8'h45, 1, 1, 8'h44, 1, 0, 0, 0, ST_LAUNCH);
        vecs[21] = mk(0, 8'h00, 1, 0, 8'h44, 1, 0, 0, 0, ST_WAIT_BUSY);
        vecs[22] = mk(0, 8'h00, 0, 0, 8'h44, 1, 0, 0, 0, ST_WAIT_DONE);
        vecs[23] = mk(0, 8'h00, 1, 0, 8'h44, 1, 0, 0, 0, ST_IDLE);
        vecs[24] = mk(0, 8'h00, 1, 1, 8'h45, 0, 0, 1, 0, ST_LAUNCH);
        vecs[25] = mk(0, 8'h00, 0, 0, 8'h45, 0, 0, 1, 0, ST_WAIT_BUSY);
        vecs[26] = mk(0, 8'h00, 0, 0, 8'h45, 0, 0, 1, 0, ST_WAIT_DONE);
        vecs[27] = mk(0, 8'h00, 1, 0, 8'h45, 0, 0, 1, 0, ST_IDLE);

        for (int i = 0; i < 28; i++) begin
            bus.i_wr      = vecs[i].wr;
            bus.i_wr_data = vecs[i].data;
            man_ready     = vecs[i].rdy;
            step();
            act_v = {bus.o_tx_start, bus.o_tx_data, bus.o_count, bus.o_full,
                     bus.o_empty, bus.o_overflow, state};
            exp_v = {vecs[i].start, vecs[i].tx_data, vecs[i].cnt, vecs[i].full,
                     vecs[i].empty, vecs[i].ovf, vecs[i].st};
            n_vec++;
            if (act_v !== exp_v) begin
                n_miss++;
                $display("FAIL vec%0d: got %05h expected %05h", i, act_v, exp_v);
            end
        end
        bus.i_wr = 1'b0;

        // Full and overflow: ready held low, 17 pushes
        man_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.i_wr      = 1'b1;
            bus.i_wr_data = 8'(8'h10 + i);
            step();
            check("fill_count", 32'(bus.o_count), (i < 16) ? 32'(i + 1) : 32'd16);
            check("fill_full", 32'(bus.o_full), (i >= 15) ? 32'd1 : 32'd0);
            check("fill_ovf", 32'(bus.o_overflow), (i == 16) ? 32'd1 : 32'd0);
        end
        bus.i_wr = 1'b0;
        step();
        check("ovf_pulse_end", 32'(bus.o_overflow), 32'd0);
        check("ovf_count_kept", 32'(bus.o_count), 32'd16);
        for (int i = 0; i < 16; i++) drain_one(8'(8'h10 + i));
        man_ready = 1'b1;
        step();
        check("drain_empty", 32'(bus.o_empty), 32'd1);
        check("drain_no_start", 32'(bus.o_tx_start), 32'd0);

        // Simultaneous push and pop at full
        man_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        check("sim_full", 32'(bus.o_full), 32'd1);
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'hEE;
        man_ready     = 1'b1;
        step();
        bus.i_wr = 1'b0;
        check("sim_count", 32'(bus.o_count), 32'd16);
        check("sim_ovf", 32'(bus.o_overflow), 32'd0);
        check("sim_start", 32'(bus.o_tx_start), 32'd1);
        check("sim_data", 32'(bus.o_tx_data), 32'h60);
        step();
        man_ready = 1'b0;
        step();
        man_ready = 1'b1;
        step();
        for (int i = 1; i < 16; i++) drain_one(8'(8'h60 + i));
        drain_one(8'hEE);
        check("sim_empty", 32'(bus.o_empty), 32'd1);

        // Burst against the transmitter model
        model_en = 1'b1;
        step();
        base   = got_q.size();
        base_s = n_starts;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            push(8'(i));
        end
        cyc = 0;
        while (!(got_q.size() - base == 5 && state == ST_IDLE && model_ready) && cyc < 1000) begin
            step();
            cyc++;
        end
        check("burst_timeout", 32'(cyc < 1000), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() != 0 && base + i < got_q.size())
                check("burst_byte", 32'(got_q[base + i]), 32'(exp_q.pop_front()));
        end
        check("burst_starts", 32'(n_starts - base_s), 32'd5);

        // Reset during WAIT_DONE with three bytes queued
        for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
        cyc = 0;
        while (!(state == ST_WAIT_DONE && bus.o_count == 3) && cyc < 100) begin
            step();
            cyc++;
        end
        check("midrst_reach", 32'(cyc < 100), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(bus.o_empty), 32'd1);
        check("midrst_count", 32'(bus.o_count), 32'd0);
        check("midrst_start", 32'(bus.o_tx_start), 32'd0);
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        repeat (2) step();
        rst_n = 1'b1;
        step();
        base   = got_q.size();
        base_s = n_starts;
        push(8'h55);
        cyc = 0;
        while (!(got_q.size() > base && state == ST_IDLE && model_ready) && cyc < 200) begin
            step();
            cyc++;
        end
        check("post_rst_timeout", 32'(cyc < 200), 32'd1);
        if (got_q.size() > base) check("post_rst_byte", 32'(got_q[base]), 32'h55);
        check("post_rst_starts", 32'(n_starts - base_s), 32'd1);
        check("hold_errors", 32'(n_hold_err), 32'd0);
        check("busy_start_errors", 32'(n_start_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
